// File: rtl/amdf_pkg.sv
// Shared types and defaults for the AMDF pitch-lag engine: state encoding,
// accumulator width helper and default frame/lag geometry.
package amdf_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_FRAME_LEN = 64;
  localparam int DEF_MIN_LAG   = 2;
  localparam int DEF_MAX_LAG   = 32;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } amdf_state_e;

  // Worst-case D(k) is (FRAME_LEN-1)*(2^DATA_W-1), which fits in this width.
  function automatic int acc_width(input int data_w, input int frame_len);
    return data_w + $clog2(frame_len);
  endfunction

endpackage

// File: rtl/amdf_lag_engine_if.sv
// Sample-in / result-out handshake bundle of the AMDF lag engine.
// master = upstream/consumer side, slave = the engine.
interface amdf_lag_engine_if
  import amdf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LAG_W  = $clog2(DEF_MAX_LAG + 1),
  parameter int ACC_W  = acc_width(DEF_DATA_W, DEF_FRAME_LEN)
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [LAG_W-1:0]  lag_out;
  logic [ACC_W-1:0]  amdf_min;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, lag_out, amdf_min, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, lag_out, amdf_min, out_valid
  );

endinterface

// File: rtl/amdf_frame_buf.sv
// One-frame sample store: a single synchronous write port and two
// combinational read ports used for x[n] and x[n+k].
module amdf_frame_buf #(
  parameter  int DATA_W    = 16,
  parameter  int FRAME_LEN = 64,
  localparam int IDX_W     = $clog2(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [IDX_W-1:0]  rd_addr_a_i,
  input  logic [IDX_W-1:0]  rd_addr_b_i,
  output logic [DATA_W-1:0] rd_data_a_o,
  output logic [DATA_W-1:0] rd_data_b_o
);

  // No reset: every word is rewritten before a frame is evaluated.
  logic [DATA_W-1:0] mem_q [FRAME_LEN];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_a_o = mem_q[rd_addr_a_i];
  assign rd_data_b_o = mem_q[rd_addr_b_i];

endmodule

// File: rtl/amdf_lag_engine.sv
// Frame-based AMDF pitch-lag engine: buffers a frame, evaluates D(k) for each
// lag and reports the smallest. Optional trace ports under AMDF_LAG_TRACE_EN.
module amdf_lag_engine
  import amdf_pkg::*;
#(
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int FRAME_LEN = DEF_FRAME_LEN,
  parameter  int MIN_LAG   = DEF_MIN_LAG,
  parameter  int MAX_LAG   = DEF_MAX_LAG,
  localparam int LAG_W     = $clog2(MAX_LAG + 1),
  localparam int ACC_W     = acc_width(DATA_W, FRAME_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  amdf_lag_engine_if.slave bus,
  output logic             busy
`ifdef AMDF_LAG_TRACE_EN
  ,
  output logic             trace_valid,
  output logic [LAG_W-1:0] trace_lag,
  output logic [ACC_W-1:0] trace_sum
`endif
);

  localparam int IDX_W = $clog2(FRAME_LEN);

  amdf_state_e       state_q;
  logic [IDX_W-1:0]  wr_idx_q;
  logic [IDX_W-1:0]  n_q;
  logic [LAG_W-1:0]  k_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  best_sum_q;
  logic [LAG_W-1:0]  best_lag_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;
  logic [LAG_W-1:0]  lag_out_q;
  logic [ACC_W-1:0]  amdf_min_q;

  logic              accept;
  logic [IDX_W-1:0]  rd_addr_b;
  logic [DATA_W-1:0] x_a;
  logic [DATA_W-1:0] x_b;
  logic [DATA_W:0]   diff;
  logic [DATA_W:0]   neg_diff;
  logic [DATA_W-1:0] abs_diff;
  logic [ACC_W-1:0]  acc_d;
  logic [IDX_W:0]    n_end;
  logic              at_end;
  logic              last_lag;
  logic              improves;

  assign accept = in_ready_q && bus.in_valid;

  amdf_frame_buf #(
    .DATA_W    (DATA_W),
    .FRAME_LEN (FRAME_LEN)
  ) u_frame_buf (
    .clk         (clk),
    .wr_en_i     (accept),
    .wr_addr_i   (wr_idx_q),
    .wr_data_i   (bus.in_data),
    .rd_addr_a_i (n_q),
    .rd_addr_b_i (rd_addr_b),
    .rd_data_a_o (x_a),
    .rd_data_b_o (x_b)
  );

  // On the compare cycle n+k wraps past the frame; that read is ignored.
  assign rd_addr_b = n_q + IDX_W'(k_q);
  assign diff      = {1'b0, x_a} - {1'b0, x_b};
  assign neg_diff  = -diff;
  assign abs_diff  = diff[DATA_W] ? neg_diff[DATA_W-1:0] : diff[DATA_W-1:0];
  assign acc_d     = acc_q + ACC_W'(abs_diff);

  assign n_end    = (IDX_W + 1)'(FRAME_LEN) - (IDX_W + 1)'(k_q);
  assign at_end   = ({1'b0, n_q} == n_end);
  assign last_lag = (k_q == LAG_W'(MAX_LAG));
  // Strict compare keeps the earlier (smaller) lag on ties.
  assign improves = (acc_q < best_sum_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FILL;
      wr_idx_q    <= '0;
      n_q         <= '0;
      k_q         <= LAG_W'(MIN_LAG);
      acc_q       <= '0;
      best_sum_q  <= '1;
      best_lag_q  <= LAG_W'(MIN_LAG);
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      lag_out_q   <= '0;
      amdf_min_q  <= '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (accept) begin
            wr_idx_q <= wr_idx_q + IDX_W'(1);
            if (wr_idx_q == IDX_W'(FRAME_LEN - 1)) begin
              state_q    <= COMPUTE;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
              n_q        <= '0;
              k_q        <= LAG_W'(MIN_LAG);
              acc_q      <= '0;
              best_sum_q <= '1;
              best_lag_q <= LAG_W'(MIN_LAG);
            end
          end
        end

        COMPUTE: begin
          if (!at_end) begin
            acc_q <= acc_d;
            n_q   <= n_q + IDX_W'(1);
          end else begin
            if (improves) begin
              best_sum_q <= acc_q;
              best_lag_q <= k_q;
            end
            acc_q <= '0;
            n_q   <= '0;
            k_q   <= k_q + LAG_W'(1);
            if (last_lag) begin
              state_q     <= OUTPUT;
              out_valid_q <= 1'b1;
              lag_out_q   <= improves ? k_q : best_lag_q;
              amdf_min_q  <= improves ? acc_q : best_sum_q;
            end
          end
        end

        OUTPUT: begin
          if (bus.out_ready) begin
            state_q     <= FILL;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            wr_idx_q    <= '0;
          end
        end

        default: begin
          state_q <= FILL;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.lag_out   = lag_out_q;
  assign bus.amdf_min  = amdf_min_q;
  assign busy          = busy_q;

`ifdef AMDF_LAG_TRACE_EN
  assign trace_valid = (state_q == COMPUTE) && at_end;
  assign trace_lag   = k_q;
  assign trace_sum   = acc_q;
`endif

endmodule

// File: tb/tb_amdf_lag_engine.sv
// Randomized self-checking bench for amdf_lag_engine against a direct
// D(k) = sum |x[n]-x[n+k]| reference; trace ports checked when enabled.
module tb_amdf_lag_engine;
  import amdf_pkg::*;

  localparam int DATA_W    = 16;
  localparam int FRAME_LEN = 64;
  localparam int MIN_LAG   = 2;
  localparam int MAX_LAG   = 32;
  localparam int LAG_W     = $clog2(MAX_LAG + 1);
  localparam int ACC_W     = acc_width(DATA_W, FRAME_LEN);

  logic clk = 1'b0;
  logic reset;
  logic busy;
`ifdef AMDF_LAG_TRACE_EN
  logic             trace_valid;
  logic [LAG_W-1:0] trace_lag;
  logic [ACC_W-1:0] trace_sum;
`endif

  always #5 clk = ~clk;

  amdf_lag_engine_if #(.DATA_W(DATA_W), .LAG_W(LAG_W), .ACC_W(ACC_W)) bus ();

  amdf_lag_engine #(
    .DATA_W    (DATA_W),
    .FRAME_LEN (FRAME_LEN),
    .MIN_LAG   (MIN_LAG),
    .MAX_LAG   (MAX_LAG)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
`ifdef AMDF_LAG_TRACE_EN
    ,
    .trace_valid (trace_valid),
    .trace_lag   (trace_lag),
    .trace_sum   (trace_sum)
`endif
  );

  int          check_cnt = 0;
  int          error_cnt = 0;
  logic [15:0] frame [FRAME_LEN];
  longint      exp_sum [MAX_LAG + 1];
  longint      exp_min;
  int          exp_lag;
  int          exp_lat;
  int          frame_no = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    check_cnt++;
    if (got !== exp) begin
      error_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic gen_frame(input int kind);
    for (int n = 0; n < FRAME_LEN; n++) begin
      case (kind)
        0:       frame[n] = 16'h1234;
        1:       frame[n] = 16'((n % 10) * 100);
        2:       frame[n] = (n % 2 == 0) ? 16'hFFFF : 16'h0000;
        3:       frame[n] = 16'($urandom_range(0, 65535));
        default: frame[n] = 16'($urandom_range(0, 7));
      endcase
    end
  endtask

  // Direct evaluation of every D(k); first strict minimum wins.
  task automatic model_frame();
    exp_min = 64'sh7FFF_FFFF_FFFF_FFFF;
    exp_lag = 0;
    for (int k = MIN_LAG; k <= MAX_LAG; k++) begin
      longint s;
      s = 0;
      for (int n = 0; n < FRAME_LEN - k; n++) begin
        int d;
        d = int'(frame[n]) - int'(frame[n + k]);
        s += (d < 0) ? -d : d;
      end
      exp_sum[k] = s;
      if (s < exp_min) begin
        exp_min = s;
        exp_lag = k;
      end
    end
  endtask

  // Returns right after the posedge that accepts the last sample.
  task automatic send_frame(input bit gaps);
    for (int i = 0; i < FRAME_LEN; i++) begin
      int w;
      w = 0;
      if (gaps) begin
        while ($urandom_range(0, 2) == 0 && w < 4) begin
          bus.in_valid = 1'b0;
          @(negedge clk);
          w++;
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = frame[i];
      w = 0;
      while (!bus.in_ready && w < 100) begin
        @(negedge clk);
        w++;
      end
      if (!bus.in_ready) begin
        chk("fill_in_ready", 0, 1);
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      if (i != FRAME_LEN - 1) @(negedge clk);
    end
  endtask

  task automatic wait_result(input string name);
    int lat;
    int tr_cnt;
    bit done;
    lat = 0;
    tr_cnt = 0;
    done = 1'b0;
    while (!done && lat < 5000) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        bus.in_valid = 1'b0;
        chk({name, ".compute_ready_busy"}, {bus.in_ready, busy}, 2'b01);
      end
`ifdef AMDF_LAG_TRACE_EN
      if (trace_valid) begin
        if (MIN_LAG + tr_cnt <= MAX_LAG) begin
          chk({name, ".trace_lag"}, trace_lag, MIN_LAG + tr_cnt);
          chk({name, ".trace_sum"}, trace_sum, exp_sum[MIN_LAG + tr_cnt]);
        end
        tr_cnt++;
      end
`endif
      if (bus.out_valid) done = 1'b1;
    end
    chk({name, ".latency"}, lat, exp_lat);
    chk({name, ".lag_out"}, bus.lag_out, exp_lag);
    chk({name, ".amdf_min"}, bus.amdf_min, exp_min);
`ifdef AMDF_LAG_TRACE_EN
    chk({name, ".trace_count"}, tr_cnt, MAX_LAG - MIN_LAG + 1);
`endif
    frame_no++;
    $display("frame %0d %s: lag %0d min %0d latency %0d (model lag %0d min %0d)",
             frame_no, name, bus.lag_out, bus.amdf_min, lat, exp_lag, exp_min);
  endtask

  // Hold out_ready low for hold cycles (0 = already high), then release.
  task automatic finish_output(input string name, input int hold);
    int unstable;
    logic [LAG_W-1:0] lag0;
    logic [ACC_W-1:0] min0;
    lag0 = bus.lag_out;
    min0 = bus.amdf_min;
    if (hold > 0) begin
      unstable = 0;
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        if (bus.lag_out !== lag0 || bus.amdf_min !== min0 || bus.out_valid !== 1'b1 ||
            bus.in_ready !== 1'b0 || busy !== 1'b1)
          unstable++;
      end
      chk({name, ".hold_unstable_cycles"}, unstable, 0);
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    chk({name, ".post_hs_valid_ready_busy"}, {bus.out_valid, bus.in_ready, busy}, 3'b010);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    reset         = 1'b0;
    exp_lat = 1;
    for (int k = MIN_LAG; k <= MAX_LAG; k++) exp_lat += FRAME_LEN - k + 1;

    repeat (3) @(negedge clk);
    chk("reset.in_ready", bus.in_ready, 1);
    chk("reset.out_valid", bus.out_valid, 0);
    chk("reset.busy", busy, 0);
    chk("reset.lag_out", bus.lag_out, 0);
    chk("reset.amdf_min", bus.amdf_min, 0);
    reset = 1'b1;
    @(negedge clk);

    // Constant frame, consumer ready before the result appears.
    gen_frame(0); model_frame();
    bus.out_ready = 1'b1;
    send_frame(1'b0);
    wait_result("const");
    finish_output("const", 0);

    // Period-10 ramp with 100 cycles of output backpressure.
    gen_frame(1); model_frame();
    send_frame(1'b0);
    wait_result("ramp10");
    finish_output("ramp10", 100);

    gen_frame(2); model_frame();
    send_frame(1'b0);
    wait_result("alt");
    finish_output("alt", $urandom_range(1, 5));

    gen_frame(1); model_frame();
    send_frame(1'b1);
    wait_result("ramp10_gaps");
    finish_output("ramp10_gaps", $urandom_range(1, 5));

    for (int r = 0; r < 4; r++) begin
      gen_frame(3 + (r % 2)); model_frame();
      send_frame(r[0]);
      wait_result((r % 2 == 0) ? "rand_full" : "rand_small");
      finish_output("rand", $urandom_range(1, 5));
    end

    // Reset in the middle of COMPUTE.
    gen_frame(1);
    send_frame(1'b0);
    repeat (500) @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("midreset.in_ready", bus.in_ready, 1);
    chk("midreset.out_valid", bus.out_valid, 0);
    chk("midreset.busy", busy, 0);
    chk("midreset.lag_out", bus.lag_out, 0);
    chk("midreset.amdf_min", bus.amdf_min, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    gen_frame(0); model_frame();
    send_frame(1'b0);
    wait_result("const_after_reset");
    finish_output("const_after_reset", 2);

    $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", check_cnt);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/amdf_lag_engine.md
# amdf_lag_engine

Frame-based Average Magnitude Difference Function engine that sits directly downstream of the FIR stage. It consumes the filtered 16-bit sample stream and buffers one frame. For every lag in a configured range it computes D(k) = Σ|x[n] − x[n+k]|, then reports the lag with the smallest D(k) as the pitch-period estimate over a valid/ready handshake.

## Interface
- DATA_W, 16, sample width; samples are unsigned.
- FRAME_LEN, 64, samples per frame; must be a power of two.
- MIN_LAG, 2, first lag evaluated; must be ≥ 1.
- MAX_LAG, 32, last lag evaluated; must satisfy MIN_LAG ≤ MAX_LAG < FRAME_LEN.
- clk  in  1  single clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  DATA_W  filtered sample from the FIR stage.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  engine accepts a sample this cycle.
- lag_out  out  $clog2(MAX_LAG+1)  lag of the minimum D(k).
- amdf_min  out  ACC_W  the minimum D(k). ACC_W = DATA_W + $clog2(FRAME_LEN).
- out_valid  out  1  lag_out and amdf_min are valid.
- out_ready  in  1  consumer accepts the result.
- busy  out  1  high in COMPUTE and OUTPUT.

## Operation
- States: FILL, COMPUTE, OUTPUT.
- FILL:
  - in_ready = 1.
  - Each in_valid && in_ready writes buf[wr_idx] and increments wr_idx.
  - After FRAME_LEN accepts: go to COMPUTE with k = MIN_LAG, n = 0, acc = 0, best_sum = all-ones, best_lag = MIN_LAG.
- COMPUTE:
  - in_ready = 0.
  - Each cycle: acc += |buf[n] − buf[n+k]|, with the difference taken at DATA_W+1 bits and the magnitude at DATA_W bits. Then n++.
  - When n reaches FRAME_LEN−k: spend one compare cycle.
    - If acc < best_sum (strict), update best_sum and best_lag. On a tie the smaller lag wins.
    - Then clear acc, set n = 0, and increment k.
  - After the compare for k = MAX_LAG: go to OUTPUT.
- OUTPUT:
  - out_valid = 1.
  - lag_out and amdf_min hold stable until out_valid && out_ready.
  - On that handshake: go to FILL with wr_idx = 0.
- Frames never overlap. Samples offered while in_ready = 0 are not consumed; the upstream stage holds them.
- Overflow cannot occur: worst case is (FRAME_LEN − 1)·(2^DATA_W − 1), which is < 2^ACC_W.
- Reset asserted at any point, including mid-frame or mid-compute:
  - All state is discarded and the state machine returns to FILL with wr_idx = 0.
  - Buffer contents do not need clearing.

## Timing
- Reset values: in_ready = 1, out_valid = 0, busy = 0, lag_out = 0, amdf_min = 0.
- Accept edge: the edge on which the FRAME_LEN-th sample is accepted.
- COMPUTE starts on the cycle after the accept edge.
- COMPUTE lasts L = Σ_{k=MIN_LAG}^{MAX_LAG} (FRAME_LEN − k + 1) cycles. With the defaults, L = 1488.
- out_valid first reads high L+1 cycles after the accept edge.
- in_ready returns to 1 on the cycle after the output handshake.
- out_ready high on the first OUTPUT cycle still gives exactly one out_valid cycle.
- in_valid gaps during FILL only stretch FILL; they never change results.

## Configuration
- AMDF_LAG_TRACE_EN:
  - Defined: adds outputs trace_valid (1), trace_lag (lag width) and trace_sum (ACC_W).
  - trace_valid pulses for exactly one cycle on each compare cycle, carrying that lag's k and acc.
  - trace_valid has no backpressure and resets to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

## Structure
- Shared package amdf_pkg holds:
  - the state enum (FILL, COMPUTE, OUTPUT);
  - an ACC_W width helper function;
  - the default frame and lag constants.
- Sub-module amdf_frame_buf: FRAME_LEN × DATA_W register array with one write port and two combinational read ports (addresses n and n+k).
- amdf_lag_engine contains the state machine, the |diff| datapath, the accumulator and the minimum tracking.

## Test plan
- Constant frame: 64 samples of 0x1234 → lag_out = 2, amdf_min = 0, out_valid first high 1489 cycles after the accept edge.
- Ramp with period 10: x[n] = (n mod 10)·100 → lag_out = 10, amdf_min = 0. Lags 20 and 30 tie and the smaller lag wins.
- Alternating 0xFFFF / 0x0000: lag_out = 2, amdf_min = 0. With AMDF_LAG_TRACE_EN there are 31 trace pulses, and the lag-3 trace_sum is 3997635.
- Backpressure: out_ready held low for 100 cycles → outputs stable, in_ready = 0, busy = 1. On release, in_ready = 1 on the next cycle.
- Random in_valid gaps with the period-10 ramp → identical result; no sample is lost or duplicated.
- Reset pulsed mid-COMPUTE → reset values on all outputs. A following constant frame gives lag_out = 2 and amdf_min = 0.
